// File: rtl/csoc_test_pkg.sv
// csoc_test_pkg: shared FSM state encoding and parameter defaults for the CSoC scan sequencer
// Contents: state_t (scan/reset sequencer states), CLK_DIV/RST_CYCLES/LEN_W defaults, SCAN_W chain count.
package csoc_test_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, PUSH, CAPTURE, FIN, SOCRST} state_t;
  localparam int CLK_DIV_DEF = 4;
  localparam int RST_CYCLES_DEF = 16;
  localparam int LEN_W_DEF = 16;
  localparam int SCAN_W = 8;
endpackage

// File: rtl/csoc_clk_phase.sv
// csoc_clk_phase: half-period timer for the generated CSoC clock
// Ports: clk, rst (async, active-high), load (restart a DIV-cycle half-period),
//        last (high on the final clk cycle of the current half-period).
module csoc_clk_phase #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last
);
  logic [7:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= 8'(DIV - 1);
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign last = cnt == '0;
endmodule

// File: rtl/csoc_scan_ctrl.sv
// csoc_scan_ctrl: scan-test sequencer driving the CSoC test pins from a byte stream
// Ports: clk/rst (async, active-high); start+shift_len, soc_rst_req requests; busy/done status;
//        in_valid/in_data/in_ready scan-in stream; out_valid/out_data/out_ready scan-out stream;
//        csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm, csoc_data_o to the CSoC, csoc_data_i from it.
// Build option: CSOC_SCAN_UNLOAD_EN enables the scan-out path; without it out_valid/out_data are tied 0.
module csoc_scan_ctrl
  import csoc_test_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  shift_len,
  input  logic              soc_rst_req,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  input  logic [SCAN_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [SCAN_W-1:0] out_data,
  input  logic              out_ready,
  output logic              csoc_clk,
  output logic              csoc_rstn,
  output logic              csoc_test_se,
  output logic              csoc_test_tm,
  input  logic [SCAN_W-1:0] csoc_data_i,
  output logic [SCAN_W-1:0] csoc_data_o
);
  state_t st;
  logic [LEN_W-1:0] len;
  logic [7:0] rcnt;
  logic ph_load, ph_last, push_go;
`ifdef CSOC_SCAN_UNLOAD_EN
  assign push_go = st == PUSH && out_valid && out_ready;
`else
  logic unused_ok;
  assign unused_ok = ^{out_ready, csoc_data_i};
  assign out_valid = 1'b0;
  assign out_data = '0;
  assign push_go = st == PUSH;
`endif
  // Restart the half-period timer whenever a timed phase (SHIFT_LO, SHIFT_HI, capture low/high) begins.
  assign ph_load = (st == IDLE && start && shift_len == '0) ||
                   (st == LOAD && in_valid && in_ready) ||
                   (st == SHIFT_LO && ph_last) ||
                   (st == CAPTURE && ph_last && !csoc_clk) ||
                   (push_go && len == LEN_W'(1));
  csoc_clk_phase #(.DIV(CLK_DIV)) u_phase (
    .clk(clk),
    .rst(rst),
    .load(ph_load),
    .last(ph_last)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      len <= '0;
      rcnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      in_ready <= 1'b0;
      csoc_clk <= 1'b0;
      csoc_rstn <= 1'b0;
      csoc_test_se <= 1'b0;
      csoc_test_tm <= 1'b0;
      csoc_data_o <= '0;
`ifdef CSOC_SCAN_UNLOAD_EN
      out_valid <= 1'b0;
      out_data <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: begin
          csoc_rstn <= 1'b1;
          if (start) begin
            busy <= 1'b1;
            csoc_test_tm <= 1'b1;
            if (shift_len != '0) begin
              len <= shift_len;
              csoc_test_se <= 1'b1;
              in_ready <= 1'b1;
              st <= LOAD;
            end else st <= CAPTURE;
          end else if (soc_rst_req) begin
            busy <= 1'b1;
            csoc_rstn <= 1'b0;
            rcnt <= 8'(RST_CYCLES - 1);
            st <= SOCRST;
          end
        end
        LOAD:
          if (in_valid && in_ready) begin
            csoc_data_o <= in_data;
            in_ready <= 1'b0;
            st <= SHIFT_LO;
          end
        SHIFT_LO:
          if (ph_last) begin
`ifdef CSOC_SCAN_UNLOAD_EN
            out_data <= csoc_data_i;
`endif
            csoc_clk <= 1'b1;
            st <= SHIFT_HI;
          end
        SHIFT_HI:
          if (ph_last) begin
            csoc_clk <= 1'b0;
`ifdef CSOC_SCAN_UNLOAD_EN
            out_valid <= 1'b1;
`endif
            st <= PUSH;
          end
        PUSH:
          if (push_go) begin
`ifdef CSOC_SCAN_UNLOAD_EN
            out_valid <= 1'b0;
`endif
            len <= len - 1'b1;
            if (len == LEN_W'(1)) begin
              csoc_test_se <= 1'b0;
              st <= CAPTURE;
            end else begin
              in_ready <= 1'b1;
              st <= LOAD;
            end
          end
        // csoc_clk doubles as the low/high sub-phase flag of the capture pulse.
        CAPTURE:
          if (ph_last) begin
            csoc_clk <= !csoc_clk;
            if (csoc_clk) begin
              csoc_test_tm <= 1'b0;
              done <= 1'b1;
              st <= FIN;
            end
          end
        FIN: begin
          busy <= 1'b0;
          st <= IDLE;
        end
        SOCRST:
          if (rcnt == '0) begin
            csoc_rstn <= 1'b1;
            done <= 1'b1;
            busy <= 1'b0;
            st <= IDLE;
          end else rcnt <= rcnt - 1'b1;
        default: st <= IDLE;
      endcase
    end
endmodule

// File: doc/csoc_scan_ctrl.md
Name: csoc_scan_ctrl

Overview:
- Scan-test sequencer for the CSoC. Sits between the UART command parser and the CSoC test pins.
- Accepts a scan operation request with a shift length, pulls scan-in bytes over a valid/ready stream, and drives csoc_clk/csoc_test_se/csoc_data_o for that many shift cycles.
- Returns the scan-out bytes sampled on csoc_data_i, then issues one capture clock with scan enable low.
- Also generates a CSoC reset pulse on request. Scan port is 8 parallel chains, one byte per shift cycle.

Parameters:
- CLK_DIV, 4, clk cycles per csoc_clk half-period; legal 1..255.
- RST_CYCLES, 16, clk cycles csoc_rstn is held low on a reset request; legal 1..255.
- LEN_W, 16, width of the shift-length field.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  one-cycle pulse; begin scan op (ignored unless idle)
- shift_len  in  LEN_W  number of shift cycles, sampled on start; 0 = capture only
- soc_rst_req  in  1  one-cycle pulse; pulse csoc_rstn low (ignored unless idle)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when an op or reset pulse completes
- in_valid  in  1  scan-in byte valid
- in_data  in  8  scan-in byte (bit i -> chain i)
- in_ready  out  1  block accepts in_data
- out_valid  out  1  scan-out byte valid
- out_data  out  8  scan-out byte (bit i <- chain i)
- out_ready  in  1  consumer accepts out_data
- csoc_clk  out  1  CSoC clock
- csoc_rstn  out  1  CSoC reset, active low
- csoc_test_se  out  1  scan enable
- csoc_test_tm  out  1  test mode
- csoc_data_i  in  8  scan-out pins
- csoc_data_o  out  8  scan-in pins

Reset and clocking (already decided):
- Reset rst, asynchronous, active-high; clock clk.

Reset values:
- csoc_clk=0, csoc_rstn=0, csoc_test_se=0, csoc_test_tm=0, csoc_data_o=0.
- busy=0, done=0, in_ready=0, out_valid=0, out_data=0.
- State IDLE, all counters 0.
- csoc_rstn goes to 1 on the first clk after rst deasserts.

All outputs are registered. FSM states:
- IDLE: tm=0, se=0, csoc_clk=0.
  - start with shift_len>0 -> LOAD; load len counter, set tm=1, se=1.
  - start with shift_len=0 -> CAPTURE; tm=1.
  - soc_rst_req -> SOCRST.
  - start and soc_rst_req in the same cycle: start wins; the reset request is dropped.
- LOAD: in_ready=1.
  - On in_valid&in_ready: latch in_data to csoc_data_o, in_ready drops the next cycle, -> SHIFT_LO.
  - Holds indefinitely; csoc_clk stays 0 while waiting.
- SHIFT_LO: csoc_clk=0 for CLK_DIV cycles.
  - On the last cycle, sample csoc_data_i into the out register, -> SHIFT_HI.
- SHIFT_HI: csoc_clk=1 for CLK_DIV cycles, then -> PUSH.
  - The CSoC sees the rising edge with csoc_data_o stable for at least CLK_DIV cycles before it.
- PUSH: out_valid=1 until out_valid&out_ready, then decrement len.
  - len=0 -> CAPTURE, else -> LOAD.
  - csoc_clk stays 0 while stalled.
- CAPTURE: se=0. Wait CLK_DIV cycles with csoc_clk low, then CLK_DIV cycles with csoc_clk high, then -> FIN.
- FIN: csoc_clk=0, tm=0, done=1 for one cycle, -> IDLE.
- SOCRST: csoc_rstn=0 for RST_CYCLES cycles, then csoc_rstn=1, done pulse, -> IDLE. tm/se stay 0.

Handshake and boundary rules:
- out_valid/out_data hold stable until accepted.
- in_ready is never high outside LOAD.
- Shift count is exact: shift_len bytes in, shift_len bytes out, shift_len rising edges, then exactly one capture edge.
- shift_len = 2^LEN_W-1 must complete without counter wrap.
- start, shift_len changes and soc_rst_req while busy are ignored.
- rst mid-operation returns to the reset values immediately. Partial in/out bytes are discarded and no done pulse is issued.

Optional Feature:
- Macro: CSOC_SCAN_UNLOAD_EN.
- Defined: behaviour as above.
- Undefined: no scan-out path.
  - out_valid=0 and out_data=0 constantly; out_ready is ignored.
  - PUSH is a single-cycle state (decrement, branch), never stalls.
  - The sampling register is removed.

Decomposition:
- Shared package csoc_test_pkg holds:
  - state enum (IDLE, LOAD, SHIFT_LO, SHIFT_HI, PUSH, CAPTURE, FIN, SOCRST);
  - defaults for CLK_DIV, RST_CYCLES, LEN_W;
  - SCAN_W=8.
- One sub-module: csoc_clk_phase, a down-counter that loads CLK_DIV-1 and flags the last cycle of a half-period. It is reused by SHIFT_LO, SHIFT_HI and CAPTURE.

Test Plan:
1. Reset, then release -> all outputs at reset values. csoc_rstn=1 one clk after release; busy=0.
2. CLK_DIV=2, start with shift_len=3, in bytes 0xA5, 0x3C, 0xFF; bench CSoC model is an 8x3-deep shift register preloaded with 0x11, 0x22, 0x33.
   - out bytes 0x11, 0x22, 0x33.
   - 3 shift edges with se=1, then 1 capture edge with se=0.
   - Model holds A5, 3C, FF.
   - done pulses once.
3. shift_len=2 with out_ready held 0 for 20 cycles after the first out_valid -> out_data stable and csoc_clk stays 0 throughout. Resumes normally after out_ready=1. in_valid delays behave the same way.
4. shift_len=0 -> no in_ready and no out_valid. Exactly one csoc_clk high phase with se=0 and tm=1, then done.
5. soc_rst_req with RST_CYCLES=16 -> csoc_rstn low for exactly 16 clk, then done. A start in the same cycle as soc_rst_req starts the scan op instead.
6. rst asserted during SHIFT_HI of byte 2 of 4 -> outputs at reset values immediately, no done pulse. A fresh start with shift_len=1 then completes correctly.
